// File: rtl/mux_key_with_default_if.sv
// Lookup bus: key/table/default in, combinational and registered selection out.
interface mux_key_with_default_if #(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1
);
  localparam int unsigned PAIR_LEN = KEY_LEN + DATA_LEN;
  localparam int unsigned LUT_LEN  = NR_KEY * PAIR_LEN;

  logic [KEY_LEN-1:0]  key;
  logic [DATA_LEN-1:0] default_out;
  logic [LUT_LEN-1:0]  lut;
  logic [DATA_LEN-1:0] out;
  logic                hit;
  logic [DATA_LEN-1:0] out_q;
  logic                hit_q;

  modport master (
    output key, default_out, lut,
    input  out, hit, out_q, hit_q
  );

  modport slave (
    input  key, default_out, lut,
    output out, hit, out_q, hit_q
  );
endinterface

// File: rtl/mux_key_with_default.sv
// Key-indexed lookup mux with fallback value; combinational result plus a
// registered copy for pipelined consumers. Lowest-index matching pair wins.
module mux_key_with_default #(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  mux_key_with_default_if.slave bus
);
  localparam int unsigned PAIR_LEN = KEY_LEN + DATA_LEN;

  logic [KEY_LEN-1:0]  pair_key  [NR_KEY];
  logic [DATA_LEN-1:0] pair_data [NR_KEY];
  logic [DATA_LEN-1:0] sel_out;
  logic                sel_hit;

  // Unpack the table: pair 0 sits in the MSBs, key above data inside a pair.
  for (genvar g = 0; g < NR_KEY; g++) begin : g_pair
    assign pair_key[g]  = bus.lut[(NR_KEY-1-g)*PAIR_LEN+DATA_LEN +: KEY_LEN];
    assign pair_data[g] = bus.lut[(NR_KEY-1-g)*PAIR_LEN +: DATA_LEN];
  end

  // Priority select: scan from the last pair down so the first match overrides.
  always_comb begin
    sel_out = bus.default_out;
    sel_hit = 1'b0;
    for (int i = int'(NR_KEY) - 1; i >= 0; i--) begin
      if (pair_key[i] == bus.key) begin
        sel_out = pair_data[i];
        sel_hit = 1'b1;
      end
    end
  end

  assign bus.out = sel_out;
  assign bus.hit = sel_hit;

  // Registered copy of the selection; cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_q <= '0;
      bus.hit_q <= 1'b0;
    end else begin
      bus.out_q <= sel_out;
      bus.hit_q <= sel_hit;
    end
  end
endmodule

// File: tb/tb_mux_key_with_default.sv
// Bench for mux_key_with_default: directed cases plus a random sweep over
// several table sizes, with a queue of expected registered outputs.
module tb_mux_key_with_default;
  localparam int unsigned KL = 7;
  localparam int unsigned DL = 32;
  localparam int unsigned PL = KL + DL;
  localparam logic [31:0] PC = 32'h8000_0010;

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t sb [$];

  mux_key_with_default_if #(.NR_KEY(3), .KEY_LEN(KL), .DATA_LEN(DL)) if3 ();
  mux_key_with_default_if #(.NR_KEY(2), .KEY_LEN(KL), .DATA_LEN(DL)) if2 ();
  mux_key_with_default_if #(.NR_KEY(1), .KEY_LEN(KL), .DATA_LEN(DL)) if1 ();
  mux_key_with_default_if #(.NR_KEY(4), .KEY_LEN(KL), .DATA_LEN(DL)) if4 ();
  mux_key_with_default_if #(.NR_KEY(8), .KEY_LEN(KL), .DATA_LEN(DL)) if8 ();

  mux_key_with_default #(.NR_KEY(3), .KEY_LEN(KL), .DATA_LEN(DL)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  mux_key_with_default #(.NR_KEY(2), .KEY_LEN(KL), .DATA_LEN(DL)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  mux_key_with_default #(.NR_KEY(1), .KEY_LEN(KL), .DATA_LEN(DL)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  mux_key_with_default #(.NR_KEY(4), .KEY_LEN(KL), .DATA_LEN(DL)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  mux_key_with_default #(.NR_KEY(8), .KEY_LEN(KL), .DATA_LEN(DL)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: first pair (in listing order) whose key equals k, else default.
  function automatic exp_t ref_model(input int n, input logic [6:0] k,
                                     input logic [31:0] dflt, input logic [8*PL-1:0] lut);
    exp_t r;
    logic [PL-1:0] pr;
    r.hit  = 1'b0;
    r.data = dflt;
    for (int i = 0; i < n; i++) begin
      pr = lut[(n-1-i)*PL +: PL];
      if (!r.hit && pr[PL-1 -: KL] == k) begin
        r.hit  = 1'b1;
        r.data = pr[DL-1:0];
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    if3.key = 7'h17; if3.default_out = 32'h1234_5678;
    if3.lut = {7'h17, PC, 7'h37, 32'h0, 7'h6F, PC};
    #1;
    n_cmp++; if (if3.out_q !== 32'h0) begin n_err++; $display("FAIL reset_out_q: got %h exp %h", if3.out_q, 32'h0); end
    n_cmp++; if (if3.hit_q !== 1'b0) begin n_err++; $display("FAIL reset_hit_q: got %b exp 0", if3.hit_q); end
    n_cmp++; if (if3.out !== PC) begin n_err++; $display("FAIL reset_comb_out: got %h exp %h", if3.out, PC); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_lookup();
    logic [6:0]  keys [3] = '{7'h17, 7'h37, 7'h33};
    exp_t        exps [3];
    exps[0] = '{hit: 1'b1, data: PC};
    exps[1] = '{hit: 1'b1, data: 32'h0};
    exps[2] = '{hit: 1'b0, data: 32'h1234_5678};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if3.key = keys[i]; #1;
      n_cmp++; if (if3.out !== exps[i].data) begin n_err++; $display("FAIL lookup_out[%0d]: got %h exp %h", i, if3.out, exps[i].data); end
      n_cmp++; if (if3.hit !== exps[i].hit) begin n_err++; $display("FAIL lookup_hit[%0d]: got %b exp %b", i, if3.hit, exps[i].hit); end
    end
  endtask

  task automatic test_duplicate();
    @(negedge clk);
    if2.lut = {7'h63, 32'h0000_AAAA, 7'h63, 32'h0000_BBBB};
    if2.key = 7'h63; if2.default_out = 32'hDEAD_BEEF; #1;
    n_cmp++; if (if2.out !== 32'h0000_AAAA) begin n_err++; $display("FAIL dup_out: got %h exp %h", if2.out, 32'h0000_AAAA); end
    n_cmp++; if (if2.hit !== 1'b1) begin n_err++; $display("FAIL dup_hit: got %b exp 1", if2.hit); end
    @(negedge clk); if2.key = 7'h64; #1;
    n_cmp++; if (if2.out !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL dup_miss_out: got %h exp %h", if2.out, 32'hDEAD_BEEF); end
  endtask

  task automatic test_registered();
    logic [6:0] keys [2] = '{7'h6F, 7'h00};
    exp_t e;
    if3.default_out = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); if3.key = keys[i];
      sb.push_back(ref_model(3, keys[i], if3.default_out, {{5*PL{1'b0}}, if3.lut}));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++; if (if3.out_q !== e.data) begin n_err++; $display("FAIL reg_out_q[%0d]: got %h exp %h", i, if3.out_q, e.data); end
      n_cmp++; if (if3.hit_q !== e.hit) begin n_err++; $display("FAIL reg_hit_q[%0d]: got %b exp %b", i, if3.hit_q, e.hit); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); if3.key = 7'h6F;
    @(posedge clk); #1;
    n_cmp++; if (if3.hit_q !== 1'b1) begin n_err++; $display("FAIL areset_pre_hit_q: got %b exp 1", if3.hit_q); end
    #2 rst_n = 1'b0; #1;
    n_cmp++; if (if3.out_q !== 32'h0) begin n_err++; $display("FAIL areset_out_q: got %h exp 0", if3.out_q); end
    n_cmp++; if (if3.hit_q !== 1'b0) begin n_err++; $display("FAIL areset_hit_q: got %b exp 0", if3.hit_q); end
    if3.key = 7'h37; #1;
    n_cmp++; if (if3.out !== 32'h0 || if3.hit !== 1'b1) begin n_err++; $display("FAIL areset_comb_37: got %h/%b exp 0/1", if3.out, if3.hit); end
    if3.key = 7'h17; #1;
    n_cmp++; if (if3.out !== PC || if3.hit !== 1'b1) begin n_err++; $display("FAIL areset_comb_17: got %h/%b exp %h/1", if3.out, if3.hit, PC); end
    @(posedge clk); #1;
    n_cmp++; if (if3.hit_q !== 1'b0) begin n_err++; $display("FAIL areset_hold_hit_q: got %b exp 0", if3.hit_q); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++; if (if3.out_q !== 32'h0) begin n_err++; $display("FAIL areset_release_out_q: got %h exp 0", if3.out_q); end
    @(posedge clk); #1;
    n_cmp++; if (if3.out_q !== PC || if3.hit_q !== 1'b1) begin n_err++; $display("FAIL areset_first_edge: got %h/%b exp %h/1", if3.out_q, if3.hit_q, PC); end
  endtask

  task automatic test_sweep(input int n, input int cycles);
    logic [8*PL-1:0] lut;
    logic [6:0]      k;
    logic [31:0]     d;
    logic [31:0]     o, oq;
    logic            h, hq;
    exp_t            e;
    for (int c = 0; c < cycles; c++) begin
      lut = '0;
      for (int i = 0; i < n; i++)
        lut[i*PL +: PL] = {7'($urandom_range(0, 11)), 32'($urandom())};
      k = 7'($urandom_range(0, 15));
      d = 32'($urandom());
      @(negedge clk);
      case (n)
        1: begin if1.key = k; if1.default_out = d; if1.lut = lut[1*PL-1:0]; end
        4: begin if4.key = k; if4.default_out = d; if4.lut = lut[4*PL-1:0]; end
        default: begin if8.key = k; if8.default_out = d; if8.lut = lut; end
      endcase
      e = ref_model(n, k, d, lut);
      sb.push_back(e);
      #1;
      case (n)
        1: begin o = if1.out; h = if1.hit; end
        4: begin o = if4.out; h = if4.hit; end
        default: begin o = if8.out; h = if8.hit; end
      endcase
      n_cmp++; if (o !== e.data) begin n_err++; $display("FAIL sweep%0d_out[%0d]: got %h exp %h", n, c, o, e.data); end
      n_cmp++; if (h !== e.hit) begin n_err++; $display("FAIL sweep%0d_hit[%0d]: got %b exp %b", n, c, h, e.hit); end
      @(posedge clk); #1;
      e = sb.pop_front();
      case (n)
        1: begin oq = if1.out_q; hq = if1.hit_q; end
        4: begin oq = if4.out_q; hq = if4.hit_q; end
        default: begin oq = if8.out_q; hq = if8.hit_q; end
      endcase
      n_cmp++; if (oq !== e.data || hq !== e.hit) begin n_err++; $display("FAIL sweep%0d_q[%0d]: got %h/%b exp %h/%b", n, c, oq, hq, e.data, e.hit); end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    if3.key = '0; if3.default_out = '0; if3.lut = '0;
    if2.key = '0; if2.default_out = '0; if2.lut = '0;
    if1.key = '0; if1.default_out = '0; if1.lut = '0;
    if4.key = '0; if4.default_out = '0; if4.lut = '0;
    if8.key = '0; if8.default_out = '0; if8.lut = '0;
    test_reset();
    test_lookup();
    test_duplicate();
    test_registered();
    test_async_reset();
    test_sweep(1, 60);
    test_sweep(4, 60);
    test_sweep(8, 60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
